// File: rtl/updn_counter_mod.sv
// ---------------------------------------------------------------------------
// updn_counter_mod
//   Parametrised up/down counter with count enable, parallel load, synchronous
//   clear, wrap/saturate mode, a terminal-event pulse and sticky
//   overflow/underflow flags. Count range is 0..MAX_VAL.
//
// Parameters
//   WIDTH       counter width in bits (1..32)
//   MAX_VAL     highest legal count, 0 < MAX_VAL <= 2^WIDTH-1
//   SAT_DEFAULT reset value of the mode register (0 = wrap, 1 = saturate)
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   clr       in   synchronous clear of count, tc and sticky flags
//   en        in   count enable
//   d         in   direction: 1 = up, 0 = down
//   load      in   synchronous parallel load strobe
//   load_val  in   value to load (clamped to MAX_VAL)
//   mode_wr   in   write strobe for the mode register
//   mode_sat  in   mode written on mode_wr: 1 = saturate, 0 = wrap
//   q         out  current count (registered)
//   at_max    out  q == MAX_VAL (combinational)
//   at_min    out  q == 0 (combinational)
//   tc        out  one-cycle registered pulse per terminal event
//   ovf       out  sticky: up-count attempted at MAX_VAL
//   udf       out  sticky: down-count attempted at 0
//
// Control semantics: there is no valid/ready handshake. Every strobe
// (clr, load, en, mode_wr) is sampled on each rising edge with priority
// rst > clr > load > en; mode_wr acts independently of that chain and the
// written mode only governs counting from the following edge onwards.
// ---------------------------------------------------------------------------
module updn_counter_mod #(
  parameter int unsigned WIDTH       = 3,
  parameter int unsigned MAX_VAL     = 7,
  parameter bit          SAT_DEFAULT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             d,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode_wr,
  input  logic             mode_sat,
  output logic [WIDTH-1:0] q,
  output logic             at_max,
  output logic             at_min,
  output logic             tc,
  output logic             ovf,
  output logic             udf
);

  localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ZERO_Q = '0;

  // Internal mode register: 1 = saturate, 0 = wrap.
  logic sat_mode;

  assign at_max = (q == MAX_Q);
  assign at_min = (q == ZERO_Q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q        <= ZERO_Q;
      tc       <= 1'b0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
      sat_mode <= SAT_DEFAULT;
    end else begin
      // The count path below reads the pre-edge sat_mode, so a write on
      // this edge only affects the next one.
      if (mode_wr) begin
        sat_mode <= mode_sat;
      end

      if (clr) begin
        q   <= ZERO_Q;
        tc  <= 1'b0;
        ovf <= 1'b0;
        udf <= 1'b0;
      end else if (load) begin
        // Out-of-range load values clamp so q never leaves 0..MAX_VAL.
        q  <= (load_val > MAX_Q) ? MAX_Q : load_val;
        tc <= 1'b0;
      end else if (en) begin
        if (d) begin
          if (q < MAX_Q) begin
            q  <= q + 1'b1;
            tc <= 1'b0;
          end else begin
            // Terminal event at the top: wrap to 0 or hold.
            q   <= sat_mode ? q : ZERO_Q;
            tc  <= 1'b1;
            ovf <= 1'b1;
          end
        end else begin
          if (q > ZERO_Q) begin
            q  <= q - 1'b1;
            tc <= 1'b0;
          end else begin
            // Terminal event at the bottom: wrap to MAX_VAL or hold.
            q   <= sat_mode ? q : MAX_Q;
            tc  <= 1'b1;
            udf <= 1'b1;
          end
        end
      end else begin
        tc <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_updn_counter_mod.sv
// ---------------------------------------------------------------------------
// tb_updn_counter_mod
//   Directed bench for updn_counter_mod (WIDTH = 3, MAX_VAL = 5, wrap reset
//   mode). The driver issues one input vector per cycle and pushes the
//   hand-computed response into exp_q; a monitor pops and compares one entry
//   just after every rising edge. Asynchronous reset is checked directly.
// ---------------------------------------------------------------------------
module tb_updn_counter_mod;

  localparam int unsigned W   = 3;
  localparam int unsigned MX  = 5;
  localparam int unsigned EW  = W + 5;
  localparam int unsigned MAX_WAIT = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic         clr = 1'b0, en = 1'b0, d = 1'b0, load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         mode_wr = 1'b0, mode_sat = 1'b0;
  logic [W-1:0] q;
  logic         at_max, at_min, tc, ovf, udf;

  updn_counter_mod #(.WIDTH(W), .MAX_VAL(MX), .SAT_DEFAULT(1'b0)) dut (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .d(d), .load(load),
    .load_val(load_val), .mode_wr(mode_wr), .mode_sat(mode_sat),
    .q(q), .at_max(at_max), .at_min(at_min), .tc(tc), .ovf(ovf), .udf(udf)
  );

  // ---------------- scoreboard ----------------
  // Word layout: {q, tc, ovf, udf, at_max, at_min}
  logic [EW-1:0] exp_q[$];
  string         tag_q[$];
  int            checks = 0;
  int            errors = 0;

  function automatic logic [EW-1:0] pack_obs();
    return {q, tc, ovf, udf, at_max, at_min};
  endfunction

  function automatic logic [EW-1:0] mk(input logic [W-1:0] eq, input logic etc,
                                       input logic eovf, input logic eudf,
                                       input logic emax, input logic emin);
    return {eq, etc, eovf, eudf, emax, emin};
  endfunction

  task automatic compare(input string tag, input logic [EW-1:0] act,
                         input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got q=%0d tc=%b ovf=%b udf=%b at_max=%b at_min=%b, want q=%0d tc=%b ovf=%b udf=%b at_max=%b at_min=%b",
               tag, act[EW-1:5], act[4], act[3], act[2], act[1], act[0],
               exp[EW-1:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Monitor: the counter presents a new output after every rising edge.
  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      compare(tag_q.pop_front(), pack_obs(), exp_q.pop_front());
    end
  end

  // ---------------- driver ----------------
  task automatic idle();
    clr = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; d = 1'b0;
    mode_wr = 1'b0; mode_sat = 1'b0;
  endtask

  // One vector per cycle; expected response follows the next rising edge.
  task automatic step(input string tag,
                      input logic c, input logic l, input logic [W-1:0] lv,
                      input logic e, input logic dir,
                      input logic mw, input logic ms,
                      input logic [EW-1:0] exp);
    @(negedge clk);
    clr = c; load = l; load_val = lv; en = e; d = dir;
    mode_wr = mw; mode_sat = ms;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int waited;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    compare("reset_state", pack_obs(), mk(3'd0, 0, 0, 0, 0, 1));

    // Count to 5, writing saturate mode on the way; reset must restore wrap.
    //          tag          clr ld lv   en d  mw ms  expected
    step("t1_up1",  0, 0, 3'd0, 1, 1, 1, 1, mk(3'd1, 0, 0, 0, 0, 0));
    step("t1_up2",  0, 0, 3'd0, 1, 1, 0, 0, mk(3'd2, 0, 0, 0, 0, 0));
    step("t1_up3",  0, 0, 3'd0, 1, 1, 0, 0, mk(3'd3, 0, 0, 0, 0, 0));
    step("t1_up4",  0, 0, 3'd0, 1, 1, 0, 0, mk(3'd4, 0, 0, 0, 0, 0));
    step("t1_up5",  0, 0, 3'd0, 1, 1, 0, 0, mk(3'd5, 0, 0, 0, 1, 0));
    @(negedge clk);
    idle();
    #2 rst = 1'b1;
    #1 compare("t1_async_rst", pack_obs(), mk(3'd0, 0, 0, 0, 0, 1));
    @(negedge clk);
    rst = 1'b0;

    // Wrap up from 0 (mode back to wrap after reset).
    step("t2_w1", 0, 0, 3'd0, 1, 1, 0, 0, mk(3'd1, 0, 0, 0, 0, 0));
    step("t2_w2", 0, 0, 3'd0, 1, 1, 0, 0, mk(3'd2, 0, 0, 0, 0, 0));
    step("t2_w3", 0, 0, 3'd0, 1, 1, 0, 0, mk(3'd3, 0, 0, 0, 0, 0));
    step("t2_w4", 0, 0, 3'd0, 1, 1, 0, 0, mk(3'd4, 0, 0, 0, 0, 0));
    step("t2_w5", 0, 0, 3'd0, 1, 1, 0, 0, mk(3'd5, 0, 0, 0, 1, 0));
    step("t2_w6", 0, 0, 3'd0, 1, 1, 0, 0, mk(3'd0, 1, 1, 0, 0, 1));
    step("t2_w7", 0, 0, 3'd0, 1, 1, 0, 0, mk(3'd1, 0, 1, 0, 0, 0));

    // Saturate down: mode write and load on the same edge.
    step("t3_ld2", 0, 1, 3'd2, 0, 0, 1, 1, mk(3'd2, 0, 1, 0, 0, 0));
    step("t3_d1",  0, 0, 3'd0, 1, 0, 0, 0, mk(3'd1, 0, 1, 0, 0, 0));
    step("t3_d2",  0, 0, 3'd0, 1, 0, 0, 0, mk(3'd0, 0, 1, 0, 0, 1));
    step("t3_d3",  0, 0, 3'd0, 1, 0, 0, 0, mk(3'd0, 1, 1, 1, 0, 1));
    // Writing wrap on this edge must not affect this edge: still saturates.
    step("t3_d4",  0, 0, 3'd0, 1, 0, 1, 0, mk(3'd0, 1, 1, 1, 0, 1));
    step("t3_wrapdn", 0, 0, 3'd0, 1, 0, 0, 0, mk(3'd5, 1, 1, 1, 1, 0));

    // Clear beats load and en, and clears sticky flags.
    step("t5_clr",  1, 1, 3'd3, 1, 1, 0, 0, mk(3'd0, 0, 0, 0, 0, 1));

    // Load clamp and load-over-en priority (en at max would wrap otherwise).
    step("t4_ld7",  0, 1, 3'd7, 1, 1, 0, 0, mk(3'd5, 0, 0, 0, 1, 0));
    step("t4_ld6",  0, 1, 3'd6, 1, 0, 0, 0, mk(3'd5, 0, 0, 0, 1, 0));
    step("t4_ld3",  0, 1, 3'd3, 1, 1, 0, 0, mk(3'd3, 0, 0, 0, 0, 0));
    step("t4_hold", 0, 0, 3'd0, 0, 1, 0, 0, mk(3'd3, 0, 0, 0, 0, 0));
    step("t4_clrld",1, 1, 3'd4, 0, 0, 0, 0, mk(3'd0, 0, 0, 0, 0, 1));

    // Direction reversal at the lower boundary in wrap mode.
    step("t6_dn0",  0, 0, 3'd0, 1, 0, 0, 0, mk(3'd5, 1, 0, 1, 1, 0));
    step("t6_upmx", 0, 0, 3'd0, 1, 1, 0, 0, mk(3'd0, 1, 1, 1, 0, 1));
    step("t6_idle", 0, 0, 3'd0, 0, 1, 0, 0, mk(3'd0, 0, 1, 1, 0, 1));

    // Saturate up with en held: tc stays high on each event.
    step("t7_ld4",  0, 1, 3'd4, 0, 0, 1, 1, mk(3'd4, 0, 1, 1, 0, 0));
    step("t7_up5",  0, 0, 3'd0, 1, 1, 0, 0, mk(3'd5, 0, 1, 1, 1, 0));
    step("t7_sat1", 0, 0, 3'd0, 1, 1, 0, 0, mk(3'd5, 1, 1, 1, 1, 0));
    step("t7_sat2", 0, 0, 3'd0, 1, 1, 0, 0, mk(3'd5, 1, 1, 1, 1, 0));
    step("t7_clr",  1, 0, 3'd0, 0, 0, 0, 0, mk(3'd0, 0, 0, 0, 0, 1));

    @(negedge clk);
    idle();

    // Let the monitor drain the queue, with a bounded wait.
    waited = 0;
    while (exp_q.size() > 0 && waited < MAX_WAIT) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d entries left, want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/updn_counter_mod.md
Name: updn_counter_mod

Overview:
- Parametrised up/down counter: next generation of the team's fixed 3-bit direction-controlled counter.
- Adds:
  - configurable width and modulus;
  - count enable;
  - parallel load;
  - synchronous clear;
  - wrap or saturate mode;
  - terminal-event pulse;
  - sticky overflow/underflow flags.
- Used as a general event/position counter in datapath and control blocks.

Parameters:
- WIDTH, 3, counter width in bits (1..32).
- MAX_VAL, 7, highest legal count. Must satisfy 0 < MAX_VAL <= 2^WIDTH-1. Count range is 0..MAX_VAL.
- SAT_DEFAULT, 0, reset value of the internal mode register: 0 = wrap, 1 = saturate.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous clear of count and sticky flags
- en  in  1  count enable
- d  in  1  direction: 1 = up, 0 = down
- load  in  1  synchronous parallel load strobe
- load_val  in  WIDTH  value to load
- mode_wr  in  1  write strobe for the mode register
- mode_sat  in  1  mode value written on mode_wr: 1 = saturate, 0 = wrap
- q  out  WIDTH  current count (registered)
- at_max  out  1  combinational: q == MAX_VAL
- at_min  out  1  combinational: q == 0
- tc  out  1  registered one-cycle pulse on a terminal event
- ovf  out  1  sticky: an up-count was attempted at MAX_VAL
- udf  out  1  sticky: a down-count was attempted at 0

Behaviour:
- Reset (rst high, asynchronous, any time):
  - q = 0, tc = 0, ovf = 0, udf = 0.
  - Mode register = SAT_DEFAULT.
  - Held while rst is high. Counting resumes on the first rising edge after deassertion.
- Priority per rising edge: rst > clr > load > en. mode_wr is independent of this priority.
- clr:
  - q <= 0, ovf <= 0, udf <= 0, tc <= 0.
  - load and en are ignored that cycle.
- load (clr low):
  - q <= load_val if load_val <= MAX_VAL, else q <= MAX_VAL (clamped).
  - tc <= 0. Sticky flags unchanged. en is ignored that cycle.
- en (clr and load low), d = 1:
  - q < MAX_VAL: q <= q + 1.
  - q == MAX_VAL, wrap mode: q <= 0, tc <= 1, ovf <= 1.
  - q == MAX_VAL, saturate mode: q holds, tc <= 1, ovf <= 1.
- en, d = 0:
  - q > 0: q <= q - 1.
  - q == 0, wrap mode: q <= MAX_VAL, tc <= 1, udf <= 1.
  - q == 0, saturate mode: q holds, tc <= 1, udf <= 1.
- en low, or no operation: q holds, tc <= 0.
- tc is high for exactly one cycle per terminal event. Consecutive events (e.g. saturated with en held) keep tc high each cycle.
- Mode register:
  - Updated on mode_wr.
  - The new mode takes effect from the next edge; the same-edge count uses the old mode.
- Arithmetic:
  - All comparisons are unsigned, WIDTH bits.
  - No intermediate value exceeds MAX_VAL or drops below 0, so no native 2^WIDTH wrap occurs when MAX_VAL < 2^WIDTH-1.
- Latency:
  - q, tc, ovf, udf update on the edge after the qualifying inputs.
  - at_max and at_min follow q combinationally.
- WIDTH = 1, MAX_VAL = 1 is legal and behaves as a toggle with flags.

Test Plan:
1. Reset mid-count:
   - Stimulus: count up to 5, assert rst between edges.
   - Response: q = 0 immediately (asynchronous), ovf = udf = tc = 0, mode = SAT_DEFAULT.
2. Wrap up:
   - Stimulus: WIDTH = 3, MAX_VAL = 5, wrap mode, en = 1, d = 1 from 0 for 7 edges.
   - Response: q = 1,2,3,4,5,0,1. tc high only in the cycle q = 0. ovf = 1 thereafter.
3. Saturate down:
   - Stimulus: mode_sat = 1 via mode_wr, load 2, en = 1, d = 0 for 4 edges.
   - Response: q = 1,0,0,0. tc high on the last two cycles. udf = 1. at_min = 1.
4. Load clamp and priority:
   - Stimulus: MAX_VAL = 5, load = 1, load_val = 7, en = 1.
   - Response: q = 5, at_max = 1, no count that cycle.
   - Follow-up: clr and load together gives q = 0.
5. Clear of sticky flags:
   - Stimulus: after ovf = 1 and udf = 1, pulse clr.
   - Response: q = 0, ovf = 0, udf = 0 next cycle.
6. Direction reversal at boundary:
   - Stimulus: in wrap mode at q = 0, en = 1, d = 0 then d = 1.
   - Response: q = MAX_VAL (tc = 1, udf = 1), then q = 0 (tc = 1, ovf = 1).
